key_entry_sequencer: RTL and testbench



---
 rtl/key_entry_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_key_entry_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_sequencer.sv
// Keypad entry sequencer: debounces raw key codes, drives digit-buffer strobes and
// hands the finished request to the link. Optional SEND_TIMEOUT_EN adds a ready-wait timeout.
module key_entry_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] key_code_i,
    input  logic       key_valid_i,
    output logic       buf_sel_o,
    output logic [3:0] buf_num_o,
    output logic       buf_push_o,
    output logic       buf_pop_o,
    output logic       buf_clr_all_o,
    output logic [2:0] digit_cnt_o,
    output logic [1:0] op_code_o,
    output logic       req_valid_o,
    input  logic       req_ready_i,
    output logic       err_o,
    output logic [1:0] state_dbg_o
);

    // state   | meaning
    // ENTER_A | collecting operand A digits
    // ENTER_B | collecting operand B digits, operator latched
    // SEND    | request offered to the link, waiting for ready
    // DONE    | request accepted, next key clears both buffers
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);
    localparam logic [2:0] MAXD     = 3'(MAX_DIGITS);

    state_t     state_q, state_d;
    logic [2:0] cnt_a_q, cnt_a_d;
    logic [2:0] cnt_b_q, cnt_b_d;
    logic [1:0] op_q, op_d;

    logic       push_q, push_d;
    logic       pop_q, pop_d;
    logic       clr_q, clr_d;
    logic       err_q, err_d;
    logic [3:0] num_q, num_d;
    logic       req_valid_q, req_valid_d;

    logic       act_push, act_pop, act_clr, act_err;

    logic [3:0] prev_code_q;
    logic       prev_valid_q;
    logic [7:0] stable_cnt_q, stable_cnt_d;
    logic       armed_q, armed_d;
    logic       key_evt;
    logic       timeout;

    logic is_digit, is_op, is_bs, is_ent;
    assign is_digit = (key_code_i <= 4'd9);
    assign is_op    = (key_code_i >= 4'd10) && (key_code_i <= 4'd13);
    assign is_bs    = (key_code_i == 4'd14);
    assign is_ent   = (key_code_i == 4'd15);

    // A sample only counts as stable if the previous sample was also a held key with the same code.
    always_comb begin
        stable_cnt_d = '0;
        if (key_valid_i && prev_valid_q && (key_code_i == prev_code_q)) begin
            stable_cnt_d = (stable_cnt_q == DB_LIMIT) ? stable_cnt_q : stable_cnt_q + 8'd1;
        end
        key_evt = armed_q && (stable_cnt_d == DB_LIMIT);
        armed_d = armed_q;
        if (!key_valid_i) begin
            armed_d = 1'b1;
        end else if (key_evt) begin
            armed_d = 1'b0;
        end
    end

`ifdef SEND_TIMEOUT_EN
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = TO_LOAD;
        if (state_q == SEND) begin
            to_cnt_d = (to_cnt_q == 16'd0) ? 16'd0 : to_cnt_q - 16'd1;
        end
    end

    assign timeout = (state_q == SEND) && (to_cnt_q == 16'd0);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            to_cnt_q <= TO_LOAD;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ENTER_A;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            op_q         <= '0;
            push_q       <= 1'b0;
            pop_q        <= 1'b0;
            clr_q        <= 1'b0;
            err_q        <= 1'b0;
            num_q        <= '0;
            req_valid_q  <= 1'b0;
            prev_code_q  <= '0;
            prev_valid_q <= 1'b0;
            stable_cnt_q <= '0;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            op_q         <= op_d;
            push_q       <= push_d;
            pop_q        <= pop_d;
            clr_q        <= clr_d;
            err_q        <= err_d;
            num_q        <= num_d;
            req_valid_q  <= req_valid_d;
            prev_code_q  <= key_code_i;
            prev_valid_q <= key_valid_i;
            stable_cnt_q <= stable_cnt_d;
            armed_q      <= armed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        op_d     = op_q;
        act_push = 1'b0;
        act_pop  = 1'b0;
        act_clr  = 1'b0;
        act_err  = 1'b0;
        case (state_q)
            ENTER_A: begin
                if (key_evt) begin
                    if (is_digit) begin
                        if (cnt_a_q < MAXD) begin
                            act_push = 1'b1;
                            cnt_a_d  = cnt_a_q + 3'd1;
                        end else begin
                            act_err = 1'b1;
                        end
                    end else if (is_bs) begin
                        if (cnt_a_q != 3'd0) begin
                            act_pop = 1'b1;
                            cnt_a_d = cnt_a_q - 3'd1;
                        end
                    end else if (is_op) begin
                        if (cnt_a_q != 3'd0) begin
                            op_d    = 2'(key_code_i - 4'd10);
                            state_d = ENTER_B;
                        end else begin
                            act_err = 1'b1;
                        end
                    end else begin
                        act_err = 1'b1;
                    end
                end
            end
            ENTER_B: begin
                if (key_evt) begin
                    if (is_digit) begin
                        if (cnt_b_q < MAXD) begin
                            act_push = 1'b1;
                            cnt_b_d  = cnt_b_q + 3'd1;
                        end else begin
                            act_err = 1'b1;
                        end
                    end else if (is_bs) begin
                        if (cnt_b_q != 3'd0) begin
                            act_pop = 1'b1;
                            cnt_b_d = cnt_b_q - 3'd1;
                        end else begin
                            state_d = ENTER_A;
                        end
                    end else if (is_op) begin
                        op_d = 2'(key_code_i - 4'd10);
                    end else if (is_ent) begin
                        if (cnt_b_q != 3'd0) begin
                            state_d = SEND;
                        end else begin
                            act_err = 1'b1;
                        end
                    end
                end
            end
            SEND: begin
                // Ready beats a simultaneous timeout.
                if (req_ready_i) begin
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = ENTER_B;
                    act_err = 1'b1;
                end
            end
            DONE: begin
                if (key_evt) begin
                    act_clr = 1'b1;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    op_d    = '0;
                    state_d = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase
    end

    always_comb begin
        push_d      = act_push;
        pop_d       = act_pop;
        clr_d       = act_clr;
        err_d       = act_err;
        num_d       = act_push ? key_code_i : num_q;
        req_valid_d = (state_d == SEND);
    end

    assign buf_sel_o     = (state_q != ENTER_A);
    assign buf_num_o     = num_q;
    assign buf_push_o    = push_q;
    assign buf_pop_o     = pop_q;
    assign buf_clr_all_o = clr_q;
    assign err_o         = err_q;
    assign digit_cnt_o   = buf_sel_o ? cnt_b_q : cnt_a_q;
    assign op_code_o     = op_q;
    assign req_valid_o   = req_valid_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Directed bench for key_entry_sequencer; checks strobes, latency, entry FSM and request handshake.
module tb_key_entry_sequencer;

    localparam int DB = 4;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic [3:0] key_code_i = '0;
    logic       key_valid_i = 1'b0;
    logic       req_ready_i = 1'b0;
    logic       buf_sel_o, buf_push_o, buf_pop_o, buf_clr_all_o, req_valid_o, err_o;
    logic [3:0] buf_num_o;
    logic [2:0] digit_cnt_o;
    logic [1:0] op_code_o, state_dbg_o;

    int total = 0;
    int bad   = 0;

    key_entry_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_DIGITS(4),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .key_code_i(key_code_i), .key_valid_i(key_valid_i),
        .buf_sel_o(buf_sel_o), .buf_num_o(buf_num_o),
        .buf_push_o(buf_push_o), .buf_pop_o(buf_pop_o), .buf_clr_all_o(buf_clr_all_o),
        .digit_cnt_o(digit_cnt_o), .op_code_o(op_code_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .err_o(err_o), .state_dbg_o(state_dbg_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        key_valid_i = 1'b0;
        req_ready_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
        tick();
    endtask

    // Strobe vector {push, pop, clr, err}; checks quiet before, expected at the event cycle, quiet after.
    task automatic press(input string tag, input logic [3:0] code, input logic [3:0] exp_stb,
                         input logic [3:0] exp_num);
        key_code_i = code;
        key_valid_i = 1'b1;
        repeat (DB) tick();
        chk({tag, "_pre"}, {12'd0, buf_push_o, buf_pop_o, buf_clr_all_o, err_o}, 16'd0);
        tick();
        chk({tag, "_stb"}, {12'd0, buf_push_o, buf_pop_o, buf_clr_all_o, err_o}, {12'd0, exp_stb});
        if (exp_stb[3]) chk({tag, "_num"}, {12'd0, buf_num_o}, {12'd0, exp_num});
        tick();
        chk({tag, "_post"}, {12'd0, buf_push_o, buf_pop_o, buf_clr_all_o, err_o}, 16'd0);
        key_valid_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int pushes, at_i, n;
        logic [3:0] pnum;

        // Reset state
        reset_i = 1'b0;
        tick();
        tick();
        chk("rst_strobes", {12'd0, buf_push_o, buf_pop_o, buf_clr_all_o, err_o}, 16'd0);
        chk("rst_req_valid", {15'd0, req_valid_o}, 16'd0);
        chk("rst_state", {14'd0, state_dbg_o}, 16'd0);
        chk("rst_misc", {6'd0, buf_sel_o, buf_num_o, digit_cnt_o, op_code_o}, 16'd0);
        reset_i = 1'b1;
        tick();

        // Three digits into A
        press("d1", 4'd1, 4'b1000, 4'd1);
        chk("d1_sel", {15'd0, buf_sel_o}, 16'd0);
        press("d2", 4'd2, 4'b1000, 4'd2);
        press("d3", 4'd3, 4'b1000, 4'd3);
        chk("d123_cnt", {13'd0, digit_cnt_o}, 16'd3);

        // Glitch while holding 7
        do_reset();
        pushes = 0; at_i = 0; pnum = 4'd0;
        key_code_i = 4'd7; key_valid_i = 1'b1;
        tick();
        tick();
        key_code_i = 4'd8;
        tick();
        key_code_i = 4'd7;
        for (int i = 1; i <= 47; i++) begin
            tick();
            if (buf_push_o) begin
                pushes++;
                at_i = i;
                pnum = buf_num_o;
            end
        end
        key_valid_i = 1'b0;
        tick();
        tick();
        chk("glitch_pushes", 16'(pushes), 16'd1);
        chk("glitch_latency", 16'(at_i), 16'd5);
        chk("glitch_num", {12'd0, pnum}, 16'd7);
        chk("glitch_cnt", {13'd0, digit_cnt_o}, 16'd1);

        // Overflow of A, backspace at zero, operator with empty A
        do_reset();
        press("bs_empty_a", 4'd14, 4'b0000, 4'd0);
        press("op_empty_a", 4'd10, 4'b0001, 4'd0);
        chk("op_empty_state", {14'd0, state_dbg_o}, 16'd0);
        press("ov1", 4'd1, 4'b1000, 4'd1);
        press("ov2", 4'd2, 4'b1000, 4'd2);
        press("ov3", 4'd3, 4'b1000, 4'd3);
        press("ov4", 4'd4, 4'b1000, 4'd4);
        press("ov5", 4'd5, 4'b0001, 4'd0);
        chk("ov_cnt", {13'd0, digit_cnt_o}, 16'd4);
        press("ent_in_a", 4'd15, 4'b0001, 4'd0);

        // Operator, B entry, backspace back into A
        do_reset();
        press("bk4", 4'd4, 4'b1000, 4'd4);
        press("bk2", 4'd2, 4'b1000, 4'd2);
        press("bk_add", 4'd10, 4'b0000, 4'd0);
        chk("bk_add_state", {14'd0, state_dbg_o}, 16'd1);
        chk("bk_add_sel_cnt", {12'd0, buf_sel_o, digit_cnt_o}, 16'h8);
        press("bk9", 4'd9, 4'b1000, 4'd9);
        chk("bk9_sel_cnt", {12'd0, buf_sel_o, digit_cnt_o}, 16'h9);
        press("bk_pop_b", 4'd14, 4'b0100, 4'd0);
        chk("bk_pop_b_cnt", {13'd0, digit_cnt_o}, 16'd0);
        press("bk_ret_a", 4'd14, 4'b0000, 4'd0);
        chk("bk_ret_state", {14'd0, state_dbg_o}, 16'd0);
        chk("bk_ret_cnt_op", {11'd0, digit_cnt_o, op_code_o}, {11'd0, 3'd2, 2'd0});
        press("bk_pop_a", 4'd14, 4'b0100, 4'd0);
        chk("bk_pop_a_cnt", {13'd0, digit_cnt_o}, 16'd1);

        // Full request with delayed ready
        do_reset();
        press("rq6", 4'd6, 4'b1000, 4'd6);
        press("rq_mul", 4'd12, 4'b0000, 4'd0);
        press("rq_div", 4'd13, 4'b0000, 4'd0);
        chk("rq_op_replace", {14'd0, op_code_o}, 16'd3);
        press("rq_mul2", 4'd12, 4'b0000, 4'd0);
        press("rq_ent_empty_b", 4'd15, 4'b0001, 4'd0);
        press("rq3", 4'd3, 4'b1000, 4'd3);
        press("rq_ent", 4'd15, 4'b0000, 4'd0);
        chk("rq_send_state", {14'd0, state_dbg_o}, 16'd2);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rq_valid_hold", {13'd0, req_valid_o, op_code_o}, {13'd0, 1'b1, 2'd2});
        end
        press("rq_key_in_send", 4'd5, 4'b0000, 4'd0);
        chk("rq_still_send", {13'd0, req_valid_o, state_dbg_o}, {13'd0, 1'b1, 2'd2});
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        chk("rq_done", {13'd0, req_valid_o, state_dbg_o}, {13'd0, 1'b0, 2'd3});
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        chk("rq_ready_in_done", {13'd0, req_valid_o, state_dbg_o}, {13'd0, 1'b0, 2'd3});
        press("rq_clr", 4'd5, 4'b0010, 4'd0);
        chk("rq_after_clr", {9'd0, state_dbg_o, buf_sel_o, digit_cnt_o, op_code_o}, 16'd0);

        // Reset while a request is pending
        press("rr1", 4'd1, 4'b1000, 4'd1);
        press("rr_sub", 4'd11, 4'b0000, 4'd0);
        press("rr2", 4'd2, 4'b1000, 4'd2);
        press("rr_ent", 4'd15, 4'b0000, 4'd0);
        chk("rr_pending", {15'd0, req_valid_o}, 16'd1);
        reset_i = 1'b0;
        tick();
        chk("rr_dropped", {13'd0, req_valid_o, state_dbg_o}, 16'd0);
        reset_i = 1'b1;
        tick();

`ifdef SEND_TIMEOUT_EN
        press("to8", 4'd8, 4'b1000, 4'd8);
        press("to_add", 4'd10, 4'b0000, 4'd0);
        press("to9", 4'd9, 4'b1000, 4'd9);
        press("to_ent", 4'd15, 4'b0000, 4'd0);
        n = 4;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req_valid_o) n++;
            else break;
        end
        chk("to_len", 16'(n), 16'd20);
        chk("to_err", {15'd0, err_o}, 16'd1);
        chk("to_state_cnt", {11'd0, state_dbg_o, digit_cnt_o}, {11'd0, 2'd1, 3'd1});
`else
        n = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
